// File: rtl/stream_out_fifo_if.sv
// Handshake bundle for stream_out_fifo: upstream word port plus AXI-Stream master side.
// 'slave' is the FIFO's view; 'master' is the view of whatever surrounds it.
interface stream_out_fifo_if #(
    parameter int W = 32
);
    logic         in_v;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         in_afull;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         m_ready;

    modport master (
        output in_v, in_data, in_last, m_ready,
        input  in_afull, m_valid, m_data, m_last
    );

    modport slave (
        input  in_v, in_data, in_last, m_ready,
        output in_afull, m_valid, m_data, m_last
    );
endinterface

// File: rtl/stream_out_fifo.sv
// Output FIFO between the stream controller and an AXI-Stream sink.
// First-word-fall-through with a registered output stage; count covers
// both the storage array and the output register, capped at DEPTH.
module stream_out_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AF    = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    stream_out_fifo_if.slave         s,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              pkt_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W:0]  mem [DEPTH];
    logic [PW:0] wptr;
    logic [PW:0] rptr;
    logic [W:0]  head_word;
    logic        accept;
    logic        mem_wr;
    logic        rd;
    logic        mem_empty;
    logic        load;

    // Handshake decode. Words are accepted against the registered count, so a
    // read on the same edge never makes room for a word arriving while full.
    // The output register reloads whenever it is empty or being consumed.
    always_comb begin
        accept    = s.in_v & (count < CW'(DEPTH));
        mem_wr    = accept & ~clear;
        rd        = s.m_valid & s.m_ready;
        mem_empty = (wptr == rptr);
        load      = ~mem_empty & (~s.m_valid | rd);
        head_word = mem[rptr[PW-1:0]];
    end

    // Almost-full throttle straight from the registered occupancy.
    always_comb begin
        s.in_afull = (count >= CW'(AF));
    end

    // Storage array: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wptr[PW-1:0]] <= {s.in_last, s.in_data};
        end
    end

    // Read/write pointers, modulo DEPTH with an extra wrap bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (mem_wr) wptr <= wptr + (PW+1)'(1);
            if (load)   rptr <= rptr + (PW+1)'(1);
        end
    end

    // Registered output stage; holds its word until the sink takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s.m_valid <= 1'b0;
            s.m_data  <= '0;
            s.m_last  <= 1'b0;
        end else if (clear) begin
            s.m_valid <= 1'b0;
        end else if (load) begin
            s.m_valid <= 1'b1;
            s.m_data  <= head_word[W-1:0];
            s.m_last  <= head_word[W];
        end else if (rd) begin
            s.m_valid <= 1'b0;
        end
    end

    // Occupancy: moving a word from the array into the output register
    // leaves the total unchanged, so only accept/read matter here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (accept & ~rd) begin
            count <= count + CW'(1);
        end else if (~accept & rd) begin
            count <= count - CW'(1);
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (s.in_v & (count == CW'(DEPTH))) begin
            overflow <= 1'b1;
        end
    end

    // Completed-packet counter, bumped on each handshake of a last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (rd & s.m_last) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_stream_out_fifo.sv
// Randomised and directed bench for stream_out_fifo with a queue-based reference model.
module tb_stream_out_fifo;
    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   pkt_cnt;

    stream_out_fifo_if #(.W(W)) bus ();

    stream_out_fifo #(.W(W), .DEPTH(DEPTH), .AF(AF)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .s        (bus),
        .count    (count),
        .overflow (overflow),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: words the FIFO must still deliver, in order.
    logic [W:0]  exp_q[$];
    logic        ovf_m = 1'b0;
    logic [15:0] pkt_m = '0;
    int          n_out = 0;
    int          occ;
    logic        hold = 1'b0;
    logic [W:0]  hold_word;
    logic [W:0]  got;
    logic [W:0]  want;

    // Model + monitor, evaluated mid-cycle on the inputs for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
            chk("rst_m_data",  64'(bus.m_data), 64'd0);
            chk("rst_count",   64'(count), 64'd0);
            chk("rst_overflow", 64'(overflow), 64'd0);
            chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
            chk("rst_afull",   64'(bus.in_afull), 64'd0);
            exp_q.delete();
            ovf_m = 1'b0;
            pkt_m = '0;
            hold  = 1'b0;
        end else begin
            occ = exp_q.size();
            chk("count",    64'(count), 64'(occ));
            chk("in_afull", 64'(bus.in_afull), 64'(occ >= AF));
            chk("overflow", 64'(overflow), 64'(ovf_m));
            chk("pkt_cnt",  64'(pkt_cnt), 64'(pkt_m));
            if (hold) begin
                chk("hold_valid", 64'(bus.m_valid), 64'd1);
                chk("hold_word",  64'({bus.m_last, bus.m_data}), 64'(hold_word));
            end
            if (bus.m_valid && bus.m_ready) begin
                got = {bus.m_last, bus.m_data};
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(got), 64'hDEAD_0000_0000);
                end else begin
                    want = exp_q.pop_front();
                    chk("out_word", 64'(got), 64'(want));
                    if (want[W]) pkt_m = pkt_m + 16'd1;
                end
                n_out++;
            end
            hold = bus.m_valid && !bus.m_ready && !clear;
            hold_word = {bus.m_last, bus.m_data};
            if (bus.in_v) begin
                if (occ < DEPTH) begin
                    if (!clear) exp_q.push_back({bus.in_last, bus.in_data});
                end else begin
                    ovf_m = 1'b1;
                end
            end
            if (clear) exp_q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] d, input logic l);
        bus.in_v    = 1'b1;
        bus.in_data = d;
        bus.in_last = l;
        step();
        bus.in_v    = 1'b0;
    endtask

    task automatic drain(input string name);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !bus.m_valid) break;
            step();
        end
        chk(name, 64'(exp_q.size() + int'(bus.m_valid)), 64'd0);
    endtask

    int base;
    int sent;

    initial begin
        bus.in_v = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_m_valid", 64'(bus.m_valid), 64'd0);

        // Single word, one-cycle latency.
        bus.m_ready = 1'b1;
        bus.in_v = 1'b1; bus.in_data = 32'hA5; bus.in_last = 1'b1;
        step();
        bus.in_v = 1'b0;
        chk("single_latency0", 64'(bus.m_valid), 64'd0);
        step();
        chk("single_valid", 64'(bus.m_valid), 64'd1);
        chk("single_data", 64'(bus.m_data), 64'hA5);
        chk("single_last", 64'(bus.m_last), 64'd1);
        step();
        chk("single_pkt", 64'(pkt_cnt), 64'd1);
        chk("single_count", 64'(count), 64'd0);

        // Backpressure to full, one dropped word, then gapless drain.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 17; i++) put(W'(i), i == 15);
        step();
        chk("bp_count", 64'(count), 64'd16);
        chk("bp_afull", 64'(bus.in_afull), 64'd1);
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_head", 64'(bus.m_data), 64'd0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("bp_nogap_valid", 64'(bus.m_valid), 64'd1);
            chk("bp_nogap_data", 64'(bus.m_data), 64'(i));
            step();
        end
        chk("bp_empty", 64'(count), 64'd0);

        // Simultaneous write and read at count 5.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) put(W'(32'h50 + i), 1'b0);
        step();
        chk("sim_pre", 64'(count), 64'd5);
        bus.m_ready = 1'b1;
        put(W'(32'h55), 1'b1);
        bus.m_ready = 1'b0;
        chk("sim_count", 64'(count), 64'd5);
        drain("sim_drain");

        // Clear with a same-cycle write; overflow survives.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 7; i++) put(W'(32'h70 + i), 1'b0);
        step();
        chk("clr_pre", 64'(count), 64'd7);
        clear = 1'b1;
        put(W'(32'h7F), 1'b1);
        clear = 1'b0;
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_valid", 64'(bus.m_valid), 64'd0);
        chk("clr_overflow", 64'(overflow), 64'd1);
        step();
        chk("clr_valid2", 64'(bus.m_valid), 64'd0);

        // Asynchronous reset mid-transfer.
        for (int i = 0; i < 3; i++) put(W'(32'h90 + i), 1'b0);
        step();
        chk("ar_pre_valid", 64'(bus.m_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(bus.m_valid), 64'd0);
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_overflow", 64'(overflow), 64'd0);
        chk("ar_afull", 64'(bus.in_afull), 64'd0);
        #4 rst = 1'b0;
        step();
        bus.m_ready = 1'b1;
        put(W'(32'h3C), 1'b1);
        step();
        chk("ar_first_valid", 64'(bus.m_valid), 64'd1);
        chk("ar_first_data", 64'(bus.m_data), 64'h3C);
        drain("ar_drain");

        // Wrap: 40 words, sink ready every other cycle, source throttled by in_afull.
        base = n_out;
        sent = 0;
        for (int c = 0; c < 400 && sent < 40; c++) begin
            bus.m_ready = ~bus.m_ready;
            bus.in_v    = !bus.in_afull;
            bus.in_data = W'(32'h1000 + sent);
            bus.in_last = (sent % 8) == 7;
            if (bus.in_v) sent++;
            step();
        end
        bus.in_v = 1'b0;
        drain("wrap_drain");
        chk("wrap_outputs", 64'(n_out - base), 64'd40);
        chk("wrap_overflow", 64'(overflow), 64'd0);

        // Random traffic, including overflow and occasional clears.
        for (int c = 0; c < 3000; c++) begin
            bus.in_v    = $urandom_range(0, 3) != 0;
            bus.in_data = W'($urandom);
            bus.in_last = $urandom_range(0, 4) == 0;
            bus.m_ready = $urandom_range(0, 2) != 0;
            clear       = $urandom_range(0, 99) == 0;
            step();
        end
        bus.in_v = 1'b0;
        clear = 1'b0;
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_out_fifo.md
STREAM_OUT_FIFO -- requirements
Module: stream_out_fifo

Interface
REQ-001 SHALL have parameter W, default 32: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries; a power of 2, at least 4.
REQ-003 SHALL have parameter AF, default 12: almost-full threshold, 1 to DEPTH-1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush of FIFO contents.
REQ-007 SHALL have port in_v, input, 1 bit: upstream word valid (driven by stream_v of the stream controller).
REQ-008 SHALL have port in_data, input, W bits: upstream result word.
REQ-009 SHALL have port in_last, input, 1 bit: marks the word as end of packet.
REQ-010 SHALL have port in_afull, output, 1 bit: count >= AF; upstream uses it as dst_ready-style throttle.
REQ-011 SHALL have port m_valid, output, 1 bit: AXI-Stream TVALID.
REQ-012 SHALL have port m_data, output, W bits: AXI-Stream TDATA.
REQ-013 SHALL have port m_last, output, 1 bit: AXI-Stream TLAST.
REQ-014 SHALL have port m_ready, input, 1 bit: AXI-Stream TREADY.
REQ-015 SHALL have port count, output, log2(DEPTH)+1 bits: words held, including the output register.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag, set when a word is dropped.
REQ-017 SHALL have port pkt_cnt, output, 16 bits: completed output packets, wraps modulo 2^16.

Function
REQ-018 SHALL store {in_last, in_data} as one entry per write; write = in_v & (count < DEPTH).
REQ-019 SHALL drop a word presented with in_v while count == DEPTH, and set overflow; a simultaneous read in that cycle does not rescue the word.
REQ-020 SHALL be first-word-fall-through with a registered output: a word written into an empty FIFO at edge N gives m_valid=1 with that word after edge N+1 (1-cycle latency).
REQ-021 SHALL treat a read as m_valid & m_ready at a rising edge; the next entry, if present, is presented on the same edge (no bubble).
REQ-022 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0; m_valid SHALL NOT drop without a handshake.
REQ-023 SHALL update count on the same edge: +1 on write only, -1 on read only, unchanged on both or neither; count never exceeds DEPTH or wraps below 0.
REQ-024 SHALL derive in_afull combinationally from registered count.
REQ-025 SHALL wrap read/write pointers modulo DEPTH, using the extra MSB to distinguish full from empty.
REQ-026 SHALL increment pkt_cnt on each read where m_last=1.
REQ-027 SHALL, on clear=1, on the next edge: empty the FIFO, set m_valid=0 and count=0, and discard any same-cycle write; overflow and pkt_cnt are kept.
REQ-028 SHALL clear overflow only on rst.
REQ-029 SHALL NOT modify in_last; packet framing is defined solely by upstream.

Reset
REQ-030 SHALL, while rst=1, immediately force m_valid=0, m_last=0, m_data=0, count=0, overflow=0, pkt_cnt=0, in_afull=0, and both pointers to 0, regardless of clk.
REQ-031 SHALL discard FIFO contents on rst asserted mid-transfer; after rst deasserts, the first accepted word is the first word output.
REQ-032 SHALL ignore in_v while rst=1.

Verification
REQ-033 Single word: empty FIFO, in_v=1, data=0xA5, last=1, m_ready=1 -> m_valid=1 with 0xA5, m_last=1 one cycle later; then pkt_cnt=1, count=0.
REQ-034 Backpressure: m_ready=0, write 16 words 0..15 -> count=16, in_afull=1 from the 12th word, m_data held at 0; a 17th word sets overflow=1 and is never output; m_ready=1 -> 0..15 output in order with no gaps.
REQ-035 Simultaneous: count=5, in_v=1 and handshake on the same edge -> count stays 5 and the order is preserved.
REQ-036 Wrap: stream 40 words with m_ready toggling every cycle -> all 40 output in order, no loss, no overflow.
REQ-037 Clear: 7 words held, clear=1 together with in_v=1 -> count=0, m_valid=0 next cycle, nothing output, overflow unchanged.
REQ-038 Async reset: rst pulsed between clock edges while m_valid=1 -> m_valid=0 immediately; a subsequent word 0x3C appears first.
